perf_counter_bank: RTL and testbench
====================================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NCH, default 4, number of independent counter channels.
REQ-002 Parameter CW, default 32, counter width per channel.
REQ-003 Parameter IW, default 32, interval (prescale) width per channel.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 state  input  NCH*8  per-channel command, channel i in bits [8i+7:8i]: 0=RESET, 1=RUN, 2=HALT, other values treated as HALT.
REQ-007 interval  input  NCH*IW  per-channel increment period in clocks; 0 treated as 1.
REQ-008 compare  input  NCH*CW  per-channel match value.
REQ-009 wrap_en  input  NCH  per-channel overflow mode: 1 = wrap to 0, 0 = saturate at all-ones.
REQ-010 clr_ovf  input  NCH  per-channel synchronous clear of the sticky overflow flag.
REQ-011 counter  output  NCH*CW  per-channel count, registered, channel i in bits [CW*i+CW-1:CW*i].
REQ-012 ovf  output  NCH  per-channel sticky overflow flag, registered.
REQ-013 match  output  NCH  per-channel one-cycle match pulse, registered.

Function
REQ-014 Each channel SHALL hold a private IW-bit prescaler pre and shall be fully independent of all other channels.
REQ-015 Effective period E = interval, or 1 if interval == 0; sampled every cycle, never latched.
REQ-016 RESET command: counter <= 0, pre <= 0, ovf <= 0, match <= 0 on the next edge.
REQ-017 HALT command: counter, pre and ovf hold; match <= 0.
REQ-018 RUN command: a tick occurs in a cycle where pre >= E-1; on a tick pre <= 0, otherwise pre <= pre+1.
REQ-019 Using >= makes a mid-count reduction of interval below the current pre produce a tick on the next RUN cycle, with no wait for pre wrap.
REQ-020 With constant E, the first increment after leaving RESET SHALL appear on the E-th consecutive RUN edge, and subsequent increments every E RUN edges.
REQ-021 HALT between RUN cycles SHALL preserve pre, so RUN time accumulates across HALT periods.
REQ-022 Tick with counter != all-ones: counter <= counter+1.
REQ-023 Tick with counter == all-ones and wrap_en=1: counter <= 0, ovf <= 1.
REQ-024 Tick with counter == all-ones and wrap_en=0: counter holds all-ones, ovf <= 1; later ticks keep ovf=1.
REQ-025 ovf SHALL remain 1 until clr_ovf=1 or RESET; if overflow and clr_ovf coincide, ovf <= 1 (set wins).
REQ-026 match <= 1 for exactly one cycle when a tick loads a counter value equal to compare; match is asserted on the same edge as that counter value.
REQ-027 Saturated counter equal to compare SHALL pulse match only on the tick that first reaches it, not on later saturating ticks.
REQ-028 A change of compare SHALL NOT by itself assert match.
REQ-029 Synchronous RESET command SHALL take priority over all other channel activity in that cycle.

Reset
REQ-030 resetn=0 SHALL immediately clear counter, pre, ovf and match on every channel, independent of clk.
REQ-031 Deassertion of resetn SHALL be treated as a synchronous release; the first RUN edge after release counts as edge 1 for REQ-020.
REQ-032 resetn asserted mid-count SHALL discard all prescaler progress; no partial tick is retained.

Verification
REQ-033 Ch0 RUN, interval=3, 10 clocks -> counter0 = 1, 2, 3 on edges 3, 6, 9; other channels held in RESET stay 0.
REQ-034 Ch1 RUN, interval=0 -> increments every edge; HALT after 5 edges for 4 clocks, then RUN 2 edges -> counter1 = 5 during HALT, 7 afterward.
REQ-035 Ch2 CW=8 build, interval=1, wrap_en=1, preload by running 255 ticks -> next tick gives counter2=0, ovf2=1; clr_ovf2 pulse -> ovf2=0; repeat with wrap_en=0 -> counter2 stays 255, ovf2=1.
REQ-036 Ch3 interval=4, compare=2 -> match3 high exactly one cycle, coincident with counter3 becoming 2 (edge 8); no further pulse while counting to 3, 4.
REQ-037 Ch0 interval=10, pre reaching 7, interval changed to 2 -> tick on next RUN edge; then ticks every 2 edges.
REQ-038 resetn pulsed low between clock edges mid-count -> all outputs 0 before the next edge; overflow coinciding with clr_ovf -> ovf stays 1.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Bank of independent, prescaled performance counters.
// Each channel has a wrap/saturate overflow policy, a sticky overflow flag and a one-shot compare-match pulse.
module perf_counter_bank #(
  parameter int NCH = 4,
  parameter int CW  = 32,
  parameter int IW  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NCH*8-1:0]  state,
  input  logic [NCH*IW-1:0] interval,
  input  logic [NCH*CW-1:0] compare,
  input  logic [NCH-1:0]    wrap_en,
  input  logic [NCH-1:0]    clr_ovf,
  output logic [NCH*CW-1:0] counter,
  output logic [NCH-1:0]    ovf,
  output logic [NCH-1:0]    match
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [IW-1:0] PRE_ONE = IW'(1);
  localparam logic [7:0]    CMD_RESET = 8'd0;
  localparam logic [7:0]    CMD_RUN   = 8'd1;

  // Returns {overflow, next value}. An all-ones count either wraps to zero or sticks.
  function automatic logic [CW:0] next_count(input logic [CW-1:0] cnt, input logic wrap);
    if (&cnt)
      return {1'b1, (wrap ? {CW{1'b0}} : cnt)};
    else
      return {1'b0, cnt + CNT_ONE};
  endfunction

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [7:0]    cmd;
    logic [IW-1:0] ivl;
    logic [IW-1:0] eff;
    logic [CW-1:0] cmp;
    logic          run;
    logic          tick;
    logic [CW:0]   nxt;
    logic          sat_hold;
    logic [CW-1:0] cnt_p0;
    logic [IW-1:0] pre_p0;
    logic          ovf_p0;
    logic          match_p0;

    assign cmd  = state[8*g +: 8];
    assign ivl  = interval[IW*g +: IW];
    assign eff  = (ivl == '0) ? PRE_ONE : ivl;
    assign cmp  = compare[CW*g +: CW];
    assign run  = (cmd == CMD_RUN);
    // Using >= lets a shrunken period fire immediately instead of waiting for pre to wrap.
    assign tick = run && (pre_p0 >= eff - PRE_ONE);
    assign nxt  = next_count(cnt_p0, wrap_en[g]);
    // A saturating tick leaves the count unchanged, so it must not re-fire the match pulse.
    assign sat_hold = nxt[CW] && !wrap_en[g];

    // Stage p0: channel state register
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt_p0   <= '0;
        pre_p0   <= '0;
        ovf_p0   <= 1'b0;
        match_p0 <= 1'b0;
      end else if (cmd == CMD_RESET) begin
        cnt_p0   <= '0;
        pre_p0   <= '0;
        ovf_p0   <= 1'b0;
        match_p0 <= 1'b0;
      end else begin
        match_p0 <= 1'b0;
        if (tick) begin
          pre_p0   <= '0;
          cnt_p0   <= nxt[CW-1:0];
          match_p0 <= (nxt[CW-1:0] == cmp) && !sat_hold;
        end else if (run) begin
          pre_p0 <= pre_p0 + PRE_ONE;
        end
        if (tick && nxt[CW])
          ovf_p0 <= 1'b1;
        else if (clr_ovf[g])
          ovf_p0 <= 1'b0;
      end
    end

    assign counter[CW*g +: CW] = cnt_p0;
    assign ovf[g]   = ovf_p0;
    assign match[g] = match_p0;
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: vector table, directed corner sequences and a random run
// against an arithmetic reference model.
module tb_perf_counter_bank;
  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int IW  = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic              clk;
  logic              resetn;
  logic [NCH*8-1:0]  state;
  logic [NCH*IW-1:0] interval;
  logic [NCH*CW-1:0] compare;
  logic [NCH-1:0]    wrap_en;
  logic [NCH-1:0]    clr_ovf;
  logic [NCH*CW-1:0] counter;
  logic [NCH-1:0]    ovf;
  logic [NCH-1:0]    match;

  int n_vec = 0;
  int n_err = 0;

  int m_cnt [NCH];
  int m_pre [NCH];
  bit m_ovf [NCH];
  bit m_match [NCH];

  typedef struct {
    logic [31:0] st;
    logic [31:0] exp_cnt;
    logic [3:0]  exp_match;
  } vec_t;
  vec_t vt [12];

  perf_counter_bank #(.NCH(NCH), .CW(CW), .IW(IW)) dut (
    .clk(clk), .resetn(resetn), .state(state), .interval(interval), .compare(compare),
    .wrap_en(wrap_en), .clr_ovf(clr_ovf), .counter(counter), .ovf(ovf), .match(match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_pre[c] = 0; m_ovf[c] = 0; m_match[c] = 0;
    end
  endfunction

  // Reference: counts ticks with plain integers; a tick is due once pre+1 reaches the period.
  function automatic void model_edge();
    for (int c = 0; c < NCH; c++) begin
      int cmd, e, cmpv, nv;
      bit ovfl;
      cmd  = int'(state[8*c +: 8]);
      e    = int'(interval[IW*c +: IW]);
      if (e == 0) e = 1;
      cmpv = int'(compare[CW*c +: CW]);
      ovfl = 0;
      if (cmd == 0) begin
        m_cnt[c] = 0; m_pre[c] = 0; m_ovf[c] = 0; m_match[c] = 0;
      end else begin
        m_match[c] = 0;
        if (cmd == 1) begin
          if (m_pre[c] + 1 >= e) begin
            m_pre[c] = 0;
            nv = m_cnt[c] + 1;
            if (nv > MAXC) begin
              ovfl = 1;
              nv = wrap_en[c] ? 0 : MAXC;
            end
            m_match[c] = (nv == cmpv) && (nv != m_cnt[c]);
            m_cnt[c] = nv;
          end else begin
            m_pre[c] = m_pre[c] + 1;
          end
        end
        if (ovfl) m_ovf[c] = 1;
        else if (clr_ovf[c]) m_ovf[c] = 0;
      end
    end
  endfunction

  task automatic check_model();
    logic [NCH*CW-1:0] ec;
    logic [NCH-1:0] eo, em;
    for (int c = 0; c < NCH; c++) begin
      ec[CW*c +: CW] = CW'(m_cnt[c]);
      eo[c] = m_ovf[c];
      em[c] = m_match[c];
    end
    chk("model_counter", 32'(counter), 32'(ec));
    chk("model_ovf", 32'(ovf), 32'(eo));
    chk("model_match", 32'(match), 32'(em));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  function automatic logic [CW-1:0] cnt_of(input int c);
    return counter[CW*c +: CW];
  endfunction

  initial begin
    resetn = 1'b0; state = '0; interval = '0; compare = '0; wrap_en = '0; clr_ovf = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_counter", 32'(counter), 32'h0);
    chk("reset_ovf", 32'(ovf), 32'h0);
    chk("reset_match", 32'(match), 32'h0);
    @(negedge clk) resetn = 1'b1;
    step();

    // ch0 E=3, ch1 E=1 with HALT window, ch2 held in RESET, ch3 E=4 compare=2
    vt[0]  = '{32'h01000101, 32'h00000100, 4'b0000};
    vt[1]  = '{32'h01000101, 32'h00000200, 4'b0000};
    vt[2]  = '{32'h01000101, 32'h00000301, 4'b0000};
    vt[3]  = '{32'h01000101, 32'h01000401, 4'b0000};
    vt[4]  = '{32'h01000101, 32'h01000501, 4'b0000};
    vt[5]  = '{32'h01000201, 32'h01000502, 4'b0000};
    vt[6]  = '{32'h01000201, 32'h01000502, 4'b0000};
    vt[7]  = '{32'h01000201, 32'h02000502, 4'b1000};
    vt[8]  = '{32'h01000201, 32'h02000503, 4'b0000};
    vt[9]  = '{32'h01000101, 32'h02000603, 4'b0000};
    vt[10] = '{32'h01000101, 32'h02000703, 4'b0000};
    vt[11] = '{32'h01000201, 32'h03000704, 4'b0000};
    interval = 32'h04000003;
    compare  = 32'h0200C8C8;
    for (int i = 0; i < 12; i++) begin
      state = vt[i].st;
      step();
      chk($sformatf("tbl%0d_counter", i), 32'(counter), vt[i].exp_cnt);
      chk($sformatf("tbl%0d_match", i), 32'(match), 32'(vt[i].exp_match));
      chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'h0);
    end

    // ch2 wrap mode: 255 ticks, then wrap with overflow and a match on 0
    state = '0; step();
    interval = 32'h00010000; compare = 32'h0; wrap_en = 4'b0100;
    state = 32'h00010000;
    repeat (255) step();
    chk("wrap_pre_counter2", 32'(cnt_of(2)), 32'd255);
    step();
    chk("wrap_counter2", 32'(cnt_of(2)), 32'd0);
    chk("wrap_ovf2", 32'(ovf[2]), 32'd1);
    chk("wrap_match2", 32'(match[2]), 32'd1);
    clr_ovf = 4'b0100;
    step();
    chk("clr_ovf2", 32'(ovf[2]), 32'd0);
    clr_ovf = '0;

    // ch2 saturate mode with compare at all-ones
    state = '0; step();
    wrap_en = '0; compare = 32'h00FF0000; state = 32'h00010000;
    repeat (255) step();
    chk("sat_first_counter2", 32'(cnt_of(2)), 32'd255);
    chk("sat_first_match2", 32'(match[2]), 32'd1);
    chk("sat_first_ovf2", 32'(ovf[2]), 32'd0);
    step();
    chk("sat_hold_counter2", 32'(cnt_of(2)), 32'd255);
    chk("sat_hold_ovf2", 32'(ovf[2]), 32'd1);
    chk("sat_hold_match2", 32'(match[2]), 32'd0);
    clr_ovf = 4'b0100;
    step();
    chk("ovf_set_wins2", 32'(ovf[2]), 32'd1);
    clr_ovf = '0;

    // ch0 period shrinks from 10 to 2 with pre at 7
    state = '0; compare = '0; step();
    interval = 32'h0000000A; state = 32'h00000001;
    repeat (7) step();
    chk("shrink_pre_counter0", 32'(cnt_of(0)), 32'd0);
    interval = 32'h00000002;
    step(); chk("shrink_e1_counter0", 32'(cnt_of(0)), 32'd1);
    step(); chk("shrink_e2_counter0", 32'(cnt_of(0)), 32'd1);
    step(); chk("shrink_e3_counter0", 32'(cnt_of(0)), 32'd2);
    step(); step(); chk("shrink_e5_counter0", 32'(cnt_of(0)), 32'd3);

    // async reset between edges mid-count, then restart counting from edge 1
    interval = 32'h00000003;
    repeat (4) step();
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("async_counter", 32'(counter), 32'h0);
    chk("async_ovf", 32'(ovf), 32'h0);
    chk("async_match", 32'(match), 32'h0);
    @(negedge clk) resetn = 1'b1;
    step(); step();
    chk("rel_e2_counter0", 32'(cnt_of(0)), 32'd0);
    step();
    chk("rel_e3_counter0", 32'(cnt_of(0)), 32'd1);

    // randomized run against the model
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NCH; c++) begin
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) state[8*c +: 8] = 8'd0;
        else if (r < 14) state[8*c +: 8] = 8'd1;
        else if (r < 18) state[8*c +: 8] = 8'd2;
        else state[8*c +: 8] = 8'($urandom_range(3, 255));
        if ($urandom_range(0, 7) == 0) interval[IW*c +: IW] = IW'($urandom_range(0, 5));
        if ($urandom_range(0, 7) == 0) compare[CW*c +: CW] = CW'($urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) wrap_en[c] = ~wrap_en[c];
        clr_ovf[c] = ($urandom_range(0, 5) == 0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
